div_seq: RTL and testbench
==========================

# div_seq

Iterative 32-bit divide sequencer for the MIPS core: accepts a DIV/DIVU request and computes quotient and remainder by restoring division. It performs all arithmetic on the shared `alu` datapath, one ALU operation per cycle, and does no subtraction or comparison of its own. It sits beside the execute stage. While `alu_sel` is high, the upstream mux gives it the ALU.

## Interface

Parameters:
- none (width fixed at 32; opcodes from `mips_defines.v`)

Ports:
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; sampled only in IDLE
- `is_signed`  in  1  1 = DIV, 0 = DIVU; captured with `start`
- `dividend`  in  32  captured with `start`
- `divisor`  in  32  captured with `start`
- `busy`  out  1  high from the cycle after accept through SGN_R
- `done`  out  1  one-cycle pulse; results valid this cycle
- `quotient`  out  32  held from `done` until next accept
- `remainder`  out  32  held from `done` until next accept
- `div_by_zero`  out  1  held with results
- `alu_sel`  out  1  block owns ALU (ABS_X..SGN_R)
- `alu_opcode`  out  5  ALU opcode (`ALU_SUBU` / `ALU_SLTU` / `ALU_PASSY`)
- `alu_op_x`  out  32  ALU X operand
- `alu_op_y`  out  32  ALU Y operand
- `alu_result`  in  32  combinational ALU result, sampled at cycle end

## Operation

- **Reset (async):** state = IDLE.
  - Outputs `busy`, `done`, `quotient`, `remainder`, `div_by_zero`, `alu_sel` = 0.
  - `alu_opcode` = `ALU_PASSY`; operands = 0.
- **Reset mid-operation:** abort immediately to the reset values above. There is no partial result.
- **IDLE:** `start`=1 captures the inputs.
  - Divisor == 0: go to DONE with `quotient`=32'hFFFFFFFF, `remainder`=dividend, `div_by_zero`=1.
  - Otherwise: clear `div_by_zero`, go to ABS_X.
- **ABS_X:**
  - If `is_signed` and dividend[31]: `ALU_SUBU` with x=0, y=dividend.
  - Else: `ALU_PASSY` with y=dividend.
  - Result loads Q register (shift source). R register = 0.
- **ABS_Y:** same operation on the divisor. Result loads D register. Iteration counter = 31.
- **CMP (one iteration, part 1):**
  - c = R[31]; S = {R[30:0], Q[31]}.
  - Issue `ALU_SLTU` with x=S, y=D.
  - ge = c | ~alu_result[0]. Latch S and ge.
- **SUB (one iteration, part 2):**
  - Issue `ALU_SUBU` with x=S, y=D.
  - R = ge ? alu_result : S.
  - Q = {Q[30:0], ge}.
  - When the counter is 0, go to SGN_Q; else decrement and return to CMP.
  - The carry rule is exact: when c=1 the true difference is < D, so the mod-2^32 result is correct.
- **SGN_Q:**
  - If signed and dividend[31] XOR divisor[31]: `ALU_SUBU` with x=0, y=Q.
  - Else: `ALU_PASSY` with y=Q.
  - Result goes to `quotient`.
- **SGN_R:**
  - If signed and dividend[31]: negate R.
  - Else: pass R.
  - Result goes to `remainder`. Remainder sign follows the dividend.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Overflow case:** signed −2^31 / −1 gives `quotient`=32'h80000000, `remainder`=0. No flag, no trap.
- **`start` outside IDLE:** ignored. There is no queueing.
- **ALU when not owned:** in IDLE and DONE, `alu_opcode`=`ALU_PASSY` and operands = 0.

## Timing

- All state, counters and result registers update on the rising edge of `clk`.
- ALU outputs are combinational from state and registers. `alu_result` is consumed in the same cycle.
- Accept at edge N (IDLE, start=1) gives this sequence:
  - ABS_X in cycle N+1
  - ABS_Y in cycle N+2
  - CMP/SUB pairs in cycles N+3..N+66
  - SGN_Q in cycle N+67
  - SGN_R in cycle N+68
  - DONE (`done`=1) in cycle N+69
- Fixed latency of 69 cycles, independent of operands and signedness.
- Divide by zero: DONE in cycle N+1.
- `busy` and `alu_sel` are high in cycles N+1..N+68 and low in DONE.
- A new `start` may be accepted in the cycle after DONE (IDLE). `done` and `start` never overlap.
- `quotient` and `remainder` change only in SGN_Q/SGN_R or on a zero-divisor accept.

## Test plan

- DIVU 100 / 7, start at N → `done` at N+69 exactly; `quotient`=14, `remainder`=2, `div_by_zero`=0; `alu_sel` high N+1..N+68.
- DIV −7 / 2 → `quotient`=32'hFFFFFFFD, `remainder`=32'hFFFFFFFF. Also check DIV 7 / −2 → 32'hFFFFFFFD, `remainder`=1.
- DIVU 32'hFFFFFFFF / 1 and 32'hFFFFFFFF / 32'h80000001 → (FFFFFFFF, 0) and (1, 7FFFFFFE). Exercises the carry path.
- DIVU 5 / 0 → `done` at N+1, `quotient`=FFFFFFFF, `remainder`=5, `div_by_zero`=1. Then DIV 9 / 3 → `div_by_zero`=0, `quotient`=3.
- DIV 32'h80000000 / 32'hFFFFFFFF → `quotient`=32'h80000000, `remainder`=0.
- `start` pulsed at N+20 with different operands → ignored; original result returned at N+69. Assert `rst` at N+30 → outputs 0 immediately, IDLE. Fresh start → correct result 69 cycles later.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative 32-bit restoring divider for DIV/DIVU.
// All arithmetic is issued to the shared execute-stage ALU, one op per cycle.
// The block itself only shifts, muxes and sequences.
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        div_by_zero,
   output logic        alu_sel,
   output logic [4:0]  alu_opcode,
   output logic [31:0] alu_op_x,
   output logic [31:0] alu_op_y,
   input  logic [31:0] alu_result
);

   // ALU opcode encodings shared with the execute-stage ALU
   localparam logic [4:0] ALU_SUBU  = 5'h03;
   localparam logic [4:0] ALU_SLTU  = 5'h07;
   localparam logic [4:0] ALU_PASSY = 5'h0F;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ABS_X = 3'd1,
      S_ABS_Y = 3'd2,
      S_CMP   = 3'd3,
      S_SUB   = 3'd4,
      S_SGN_Q = 3'd5,
      S_SGN_R = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   state_t      r_state;
   logic [31:0] r_quotient;
   logic [31:0] r_remainder;
   logic        r_dbz;

   logic        r_signed;
   logic [31:0] r_dvd;
   logic [31:0] r_dvs;
   logic [31:0] r_q;
   logic [31:0] r_r;
   logic [31:0] r_d;
   logic [31:0] r_s;
   logic        r_ge;
   logic [4:0]  r_cnt;

   logic [31:0] w_shift;
   logic        w_dvd_neg;
   logic        w_dvs_neg;
   logic        w_q_neg;

   // Negate (0 - y) when the operand is negative, otherwise pass it through
   function automatic logic [4:0] f_neg_or_pass(input logic neg);
      return neg ? ALU_SUBU : ALU_PASSY;
   endfunction

   assign w_shift   = {r_r[30:0], r_q[31]};
   assign w_dvd_neg = r_signed & r_dvd[31];
   assign w_dvs_neg = r_signed & r_dvs[31];
   assign w_q_neg   = w_dvd_neg ^ w_dvs_neg;

   assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
   assign alu_sel     = busy;
   assign done        = (r_state == S_DONE);
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

   // ALU request for the current state; idle/done leaves the ALU on a harmless pass of 0
   always_comb begin
      alu_opcode = ALU_PASSY;
      alu_op_x   = 32'd0;
      alu_op_y   = 32'd0;
      case (r_state)
         S_ABS_X: begin
            alu_opcode = f_neg_or_pass(w_dvd_neg);
            alu_op_y   = r_dvd;
         end
         S_ABS_Y: begin
            alu_opcode = f_neg_or_pass(w_dvs_neg);
            alu_op_y   = r_dvs;
         end
         S_CMP: begin
            alu_opcode = ALU_SLTU;
            alu_op_x   = w_shift;
            alu_op_y   = r_d;
         end
         S_SUB: begin
            alu_opcode = ALU_SUBU;
            alu_op_x   = r_s;
            alu_op_y   = r_d;
         end
         S_SGN_Q: begin
            alu_opcode = f_neg_or_pass(w_q_neg);
            alu_op_y   = r_q;
         end
         S_SGN_R: begin
            alu_opcode = f_neg_or_pass(w_dvd_neg);
            alu_op_y   = r_r;
         end
         default: begin
            alu_opcode = ALU_PASSY;
         end
      endcase
   end

   // Control FSM and visible result registers; reset aborts any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_quotient  <= 32'd0;
         r_remainder <= 32'd0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (divisor == 32'd0) begin
                     r_quotient  <= 32'hFFFF_FFFF;
                     r_remainder <= dividend;
                     r_dbz       <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_dbz   <= 1'b0;
                     r_state <= S_ABS_X;
                  end
               end
            end
            S_ABS_X: r_state <= S_ABS_Y;
            S_ABS_Y: r_state <= S_CMP;
            S_CMP:   r_state <= S_SUB;
            S_SUB:   r_state <= (r_cnt == 5'd0) ? S_SGN_Q : S_CMP;
            S_SGN_Q: begin
               r_quotient <= alu_result;
               r_state    <= S_SGN_R;
            end
            S_SGN_R: begin
               r_remainder <= alu_result;
               r_state     <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Division datapath: operand capture, magnitudes, shift/restore iterations
   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE: begin
            if (start) begin
               r_signed <= is_signed;
               r_dvd    <= dividend;
               r_dvs    <= divisor;
            end
         end
         S_ABS_X: begin
            r_q <= alu_result;
            r_r <= 32'd0;
         end
         S_ABS_Y: begin
            r_d   <= alu_result;
            r_cnt <= 5'd31;
         end
         S_CMP: begin
            // A bit shifted out of R means S >= 2^32 > D, so subtract regardless of SLTU
            r_s  <= w_shift;
            r_ge <= r_r[31] | ~alu_result[0];
         end
         S_SUB: begin
            r_r <= r_ge ? alu_result : r_s;
            r_q <= {r_q[30:0], r_ge};
            if (r_cnt != 5'd0) begin
               r_cnt <= r_cnt - 5'd1;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq with a behavioural model of the shared ALU.
module tb_div_seq;

   localparam logic [4:0] ALU_SUBU  = 5'h03;
   localparam logic [4:0] ALU_SLTU  = 5'h07;
   localparam logic [4:0] ALU_PASSY = 5'h0F;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
   logic        alu_sel;
   logic [4:0]  alu_opcode;
   logic [31:0] alu_op_x;
   logic [31:0] alu_op_y;
   logic [31:0] alu_result;

   int n_checks;
   int n_errors;

   div_seq dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .is_signed  (is_signed),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .alu_sel    (alu_sel),
      .alu_opcode (alu_opcode),
      .alu_op_x   (alu_op_x),
      .alu_op_y   (alu_op_y),
      .alu_result (alu_result)
   );

   // Shared ALU model
   always_comb begin
      alu_result = 32'd0;
      case (alu_opcode)
         ALU_SUBU:  alu_result = alu_op_x - alu_op_y;
         ALU_SLTU:  alu_result = {31'd0, (alu_op_x < alu_op_y)};
         ALU_PASSY: alu_result = alu_op_y;
         default:   alu_result = 32'hDEAD_BEEF;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One division; inj_at > 0 pulses start with other operands in that busy cycle
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_dbz,
                          input int exp_lat, input int inj_at);
      int lat;
      int bad_own;
      logic [31:0] q_held;
      lat     = 0;
      bad_own = 0;
      @(negedge clk);
      start     = 1'b1;
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      @(posedge clk);
      for (int k = 1; k <= 100; k++) begin
         #1;
         start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (!busy || !alu_sel) bad_own++;
         if (k == inj_at) begin
            start     = 1'b1;
            is_signed = ~sgn;
            dividend  = 32'h0000_1234;
            divisor   = 32'h0000_0005;
         end
         @(posedge clk);
      end
      start = 1'b0;
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_own"}, bad_own, 0);
      chk({tag, "_q"}, quotient, exp_q);
      chk({tag, "_r"}, remainder, exp_r);
      chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
      chk({tag, "_busy_done"}, {30'd0, busy, alu_sel}, 32'd0);
      q_held = quotient;
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_q_hold"}, quotient, exp_q);
      chk({tag, "_idle_alu"}, {alu_opcode, 27'd0}, {ALU_PASSY, 27'd0});
      chk({tag, "_idle_ops"}, alu_op_x | alu_op_y, 32'd0);
      if (q_held !== quotient) chk({tag, "_q_stable"}, quotient, q_held);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = 32'd0;
      divisor   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {28'd0, busy, done, div_by_zero, alu_sel}, 32'd0);
      chk("rst_q", quotient, 32'd0);
      chk("rst_r", remainder, 32'd0);
      chk("rst_alu", {27'd0, alu_opcode}, {27'd0, ALU_PASSY});
      @(negedge clk);
      rst = 1'b0;

      run_div("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 69, 0);
      run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 69, 0);
      run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 69, 0);
      run_div("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 69, 0);
      run_div("divu_carry",  1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE, 1'b0, 69, 0);
      run_div("divu_5_0",    1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 1,  0);
      run_div("div_9_3",     1'b1, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 69, 0);
      run_div("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 69, 0);
      run_div("divu_ignore", 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 69, 20);

      // Reset in the middle of an operation
      @(negedge clk);
      start     = 1'b1;
      is_signed = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", {28'd0, busy, done, div_by_zero, alu_sel}, 32'd0);
      chk("mid_rst_q", quotient, 32'd0);
      chk("mid_rst_r", remainder, 32'd0);
      chk("mid_rst_alu", {27'd0, alu_opcode}, {27'd0, ALU_PASSY});
      chk("mid_rst_ops", alu_op_x | alu_op_y, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_div("after_rst",   1'b0, 32'h1234_5678, 32'd3,         32'h0611_7228, 32'd0,         1'b0, 69, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
